// File: rtl/reservation_station.sv
// Reservation station: holds issued instructions until both source operands
// are present, captures operands from the common data bus, and dispatches one
// ready instruction per cycle to the ALU through a registered output stage.
//
// Ports:
//   clk, rst          - single clock, asynchronous active-high reset
//   ena, in_*         - issue request and payload from decode
//   full              - all entries occupied (combinational from valid bits)
//   cdb_*             - common data bus broadcast (tag 0 is ignored)
//   flush             - discard every entry and any dispatch in flight
//   alu_ready         - ALU can take an instruction next cycle
//   out_valid, out_*  - registered dispatch strobe and payload
//
// Build option: define RS_AGE_ORDER_EN to dispatch the oldest ready entry;
// without it the lowest-index ready entry is dispatched and no age state exists.
module reservation_station #(
  parameter int RS_SIZE = 8,
  parameter int DATA_W  = 32,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_operand1,
  input  logic [DATA_W-1:0] in_operand2,
  input  logic [ROB_W-1:0]  in_tag1,
  input  logic [ROB_W-1:0]  in_tag2,
  input  logic [ROB_W-1:0]  in_rob_tag,
  output logic              full,
  input  logic              cdb_valid,
  input  logic [ROB_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              flush,
  input  logic              alu_ready,
  output logic              out_valid,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_operand1,
  output logic [DATA_W-1:0] out_operand2,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc,
  output logic [ROB_W-1:0]  out_rob_tag
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] opnd1;
    logic [DATA_W-1:0] opnd2;
    logic [ROB_W-1:0]  tag1;
    logic [ROB_W-1:0]  tag2;
    logic [ROB_W-1:0]  rob_tag;
  } entry_t;

  // Entry state
  logic [RS_SIZE-1:0] valid_q, valid_d;
  entry_t             ent_q [RS_SIZE];
  entry_t             ent_d [RS_SIZE];

  // Output stage
  logic              out_valid_q;
  logic [OP_W-1:0]   out_op_q;
  logic [DATA_W-1:0] out_opnd1_q, out_opnd2_q, out_imm_q, out_pc_q;
  logic [ROB_W-1:0]  out_rob_tag_q;

  // Control
  logic [RS_SIZE-1:0] ready;
  logic [RS_SIZE-1:0] cand;
  logic [IDX_W-1:0]   alloc_idx, sel_idx;
  logic               alloc_found, sel_found;
  logic               issue_en, disp_en, cdb_hit;
  entry_t             new_ent;

  assign full    = &valid_q;
  assign cdb_hit = cdb_valid && (cdb_tag != '0);

  // Readiness uses registered tags only, so a wakeup at edge N can first
  // dispatch at edge N+1 and a fresh issue is never seen in its own cycle.
  always_comb begin
    ready = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = valid_q[i] && (ent_q[i].tag1 == '0) && (ent_q[i].tag2 == '0);
    end
  end

  // Lowest-index free slot, from current valid bits (no same-cycle reuse).
  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        alloc_idx   = IDX_W'(i);
        alloc_found = 1'b1;
      end
    end
  end

`ifdef RS_AGE_ORDER_EN
  // older_q[i][j] set means entry i was accepted before entry j. Rows and
  // columns of a slot are rewritten when it is allocated, so stale bits
  // belonging to free slots never matter.
  logic [RS_SIZE-1:0] older_q [RS_SIZE];
  logic [RS_SIZE-1:0] older_d [RS_SIZE];
  logic [RS_SIZE-1:0] blocked;

  always_comb begin
    blocked = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        if (ready[j] && older_q[j][i]) blocked[i] = 1'b1;
      end
    end
    cand = ready & ~blocked;
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) older_d[i] = older_q[i];
    if (issue_en) begin
      older_d[alloc_idx] = '0;
      for (int j = 0; j < RS_SIZE; j++) begin
        older_d[j][alloc_idx] = valid_q[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_SIZE; i++) older_q[i] <= older_d[i];
  end
`else
  always_comb begin
    cand = ready;
  end
`endif

  // Pick the lowest-index candidate (only one exists in age-ordered mode).
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign issue_en = ena && alloc_found && !flush;
  assign disp_en  = alu_ready && sel_found && !flush;

  // Incoming entry, capturing a same-cycle CDB result for either source.
  always_comb begin
    new_ent.op      = in_op;
    new_ent.imm     = in_imm;
    new_ent.pc      = in_pc;
    new_ent.opnd1   = in_operand1;
    new_ent.opnd2   = in_operand2;
    new_ent.tag1    = in_tag1;
    new_ent.tag2    = in_tag2;
    new_ent.rob_tag = in_rob_tag;
    if (cdb_hit && (in_tag1 == cdb_tag)) begin
      new_ent.opnd1 = cdb_value;
      new_ent.tag1  = '0;
    end
    if (cdb_hit && (in_tag2 == cdb_tag)) begin
      new_ent.opnd2 = cdb_value;
      new_ent.tag2  = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      if (cdb_hit && valid_q[i]) begin
        if (ent_q[i].tag1 == cdb_tag) begin
          ent_d[i].opnd1 = cdb_value;
          ent_d[i].tag1  = '0;
        end
        if (ent_q[i].tag2 == cdb_tag) begin
          ent_d[i].opnd2 = cdb_value;
          ent_d[i].tag2  = '0;
        end
      end
      if (issue_en && (alloc_idx == IDX_W'(i))) ent_d[i] = new_ent;
    end
  end

  // Flush wins over everything; otherwise dispatch frees and issue fills.
  always_comb begin
    valid_d = valid_q;
    if (disp_en)  valid_d[sel_idx]   = 1'b0;
    if (issue_en) valid_d[alloc_idx] = 1'b1;
    if (flush)    valid_d            = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      out_valid_q   <= 1'b0;
      out_op_q      <= '0;
      out_opnd1_q   <= '0;
      out_opnd2_q   <= '0;
      out_imm_q     <= '0;
      out_pc_q      <= '0;
      out_rob_tag_q <= '0;
    end else begin
      valid_q     <= valid_d;
      out_valid_q <= disp_en;
      if (disp_en) begin
        out_op_q      <= ent_q[sel_idx].op;
        out_opnd1_q   <= ent_q[sel_idx].opnd1;
        out_opnd2_q   <= ent_q[sel_idx].opnd2;
        out_imm_q     <= ent_q[sel_idx].imm;
        out_pc_q      <= ent_q[sel_idx].pc;
        out_rob_tag_q <= ent_q[sel_idx].rob_tag;
      end
    end
  end

  // Payload storage is qualified by valid_q and needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
  end

  assign out_valid    = out_valid_q;
  assign out_op       = out_op_q;
  assign out_operand1 = out_opnd1_q;
  assign out_operand2 = out_opnd2_q;
  assign out_imm      = out_imm_q;
  assign out_pc       = out_pc_q;
  assign out_rob_tag  = out_rob_tag_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed testbench for reservation_station: issue/dispatch latency, CDB
// wakeup and issue bypass, full handling, flush, async reset, select order.
// Expected values are hand-computed per scenario.
module tb_reservation_station;
  localparam int RS = 8;
  localparam int DW = 32;
  localparam int RW = 4;
  localparam int OW = 6;

  logic          clk = 1'b0;
  logic          rst, ena, full, cdb_valid, flush, alu_ready, out_valid;
  logic [OW-1:0] in_op, out_op;
  logic [DW-1:0] in_imm, in_pc, in_operand1, in_operand2, cdb_value;
  logic [DW-1:0] out_operand1, out_operand2, out_imm, out_pc;
  logic [RW-1:0] in_tag1, in_tag2, in_rob_tag, cdb_tag, out_rob_tag;

  int n_tests = 0;
  int n_fail  = 0;

  reservation_station #(.RS_SIZE(RS), .DATA_W(DW), .ROB_W(RW), .OP_W(OW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_op(in_op), .in_imm(in_imm),
    .in_pc(in_pc), .in_operand1(in_operand1), .in_operand2(in_operand2),
    .in_tag1(in_tag1), .in_tag2(in_tag2), .in_rob_tag(in_rob_tag),
    .full(full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .flush(flush), .alu_ready(alu_ready),
    .out_valid(out_valid), .out_op(out_op), .out_operand1(out_operand1),
    .out_operand2(out_operand2), .out_imm(out_imm), .out_pc(out_pc),
    .out_rob_tag(out_rob_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [OW-1:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [RW-1:0] t1,
                       input logic [RW-1:0] t2, input logic [RW-1:0] rob);
    ena         = 1'b1;
    in_op       = op;
    in_operand1 = a;
    in_operand2 = b;
    in_tag1     = t1;
    in_tag2     = t2;
    in_rob_tag  = rob;
    in_imm      = DW'(rob) << 4;
    in_pc       = 32'h1000 + DW'(rob);
  endtask

  task automatic cdb(input logic v, input logic [RW-1:0] t, input logic [DW-1:0] val);
    cdb_valid = v;
    cdb_tag   = t;
    cdb_value = val;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ena = 1'b0; flush = 1'b0; alu_ready = 1'b1;
    in_op = '0; in_imm = '0; in_pc = '0; in_operand1 = '0; in_operand2 = '0;
    in_tag1 = '0; in_tag2 = '0; in_rob_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;

    // Reset state
    tick(); tick();
    chk("rst_full", full, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_op", out_op, 0);
    chk("rst_out_opnd1", out_operand1, 0);
    chk("rst_out_rob", out_rob_tag, 0);
    rst = 1'b0;

    // Ready issue: dispatch pulse two edges after issue
    issue(6'd1, 32'd5, 32'd7, 4'd0, 4'd0, 4'd4);
    tick();
    ena = 1'b0;
    chk("add_early", out_valid, 0);
    chk("add_full", full, 0);
    tick();
    chk("add_valid", out_valid, 1);
    chk("add_op", out_op, 1);
    chk("add_opnd1", out_operand1, 5);
    chk("add_opnd2", out_operand2, 7);
    chk("add_rob", out_rob_tag, 4);
    chk("add_imm", out_imm, 32'h40);
    chk("add_pc", out_pc, 32'h1004);
    tick();
    chk("add_pulse", out_valid, 0);
    chk("add_hold", out_operand1, 5);

    // CDB with tag 0 must not touch any operand
    alu_ready = 1'b0;
    issue(6'd2, 32'hAA, 32'hBB, 4'd0, 4'd0, 4'd6);
    cdb(1'b1, 4'd0, 32'hBAD);
    tick();
    ena = 1'b0;
    tick();
    chk("tag0_stall", out_valid, 0);
    alu_ready = 1'b1;
    cdb(1'b0, 4'd0, 32'd0);
    tick();
    chk("tag0_valid", out_valid, 1);
    chk("tag0_opnd1", out_operand1, 32'hAA);
    chk("tag0_opnd2", out_operand2, 32'hBB);

    // Dependent issue woken 4 cycles later
    issue(6'd2, 32'hDEAD, 32'h22, 4'd3, 4'd0, 4'd5);
    tick();
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("dep_wait", out_valid, 0);
      tick();
    end
    chk("dep_wait", out_valid, 0);
    cdb(1'b1, 4'd3, 32'h1234);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    chk("dep_wake_edge", out_valid, 0);
    tick();
    chk("dep_valid", out_valid, 1);
    chk("dep_opnd1", out_operand1, 32'h1234);
    chk("dep_opnd2", out_operand2, 32'h22);
    chk("dep_rob", out_rob_tag, 5);
    tick();

    // Issue bypass from same-cycle CDB
    issue(6'd4, 32'hDEAD, 32'h3, 4'd5, 4'd0, 4'd11);
    cdb(1'b1, 4'd5, 32'd9);
    tick();
    ena = 1'b0;
    cdb(1'b0, 4'd0, 32'd0);
    chk("byp_early", out_valid, 0);
    tick();
    chk("byp_valid", out_valid, 1);
    chk("byp_opnd1", out_operand1, 9);
    chk("byp_rob", out_rob_tag, 11);
    tick();

    // Fill all entries, 9th issue ignored, drain one per cycle
    for (int k = 0; k < 8; k++) begin
      issue(6'd3, 32'hEE, DW'(k), 4'd2, 4'd0, RW'(k + 1));
      tick();
    end
    chk("fill_full", full, 1);
    issue(6'd3, 32'hEE, 32'h99, 4'd0, 4'd0, 4'd9);
    tick();
    ena = 1'b0;
    chk("fill_9th_full", full, 1);
    chk("fill_no_disp", out_valid, 0);
    cdb(1'b1, 4'd2, 32'h77);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    chk("fill_wake_edge", out_valid, 0);
    chk("fill_wake_full", full, 1);
    tick();
    chk("drain0_valid", out_valid, 1);
    chk("drain0_rob", out_rob_tag, 1);
    chk("drain0_opnd1", out_operand1, 32'h77);
    chk("drain0_full", full, 0);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("drain_valid", out_valid, 1);
      chk("drain_rob", out_rob_tag, 64'(k + 1));
      chk("drain_opnd2", out_operand2, 64'(k));
    end
    tick();
    chk("drain_done", out_valid, 0);

    // Flush with issue and CDB active in the same cycle
    for (int k = 0; k < 4; k++) begin
      issue(6'd1, 32'h1, 32'h2, 4'd6, 4'd0, RW'(k + 1));
      tick();
    end
    issue(6'd1, 32'h5, 32'h5, 4'd0, 4'd0, 4'd12);
    cdb(1'b1, 4'd6, 32'h66);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ena = 1'b0;
    cdb(1'b0, 4'd0, 32'd0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_full", full, 0);
    cdb(1'b1, 4'd6, 32'h66);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    chk("flush_gone1", out_valid, 0);
    tick();
    chk("flush_gone2", out_valid, 0);
    tick();
    chk("flush_gone3", out_valid, 0);

    // Asynchronous reset mid-stream
    alu_ready = 1'b0;
    issue(6'd1, 32'h31, 32'h32, 4'd0, 4'd0, 4'd7);
    tick();
    issue(6'd1, 32'h41, 32'h42, 4'd0, 4'd0, 4'd8);
    tick();
    ena = 1'b0;
    alu_ready = 1'b1;
    tick();
    chk("arst_pre_valid", out_valid, 1);
    chk("arst_pre_rob", out_rob_tag, 7);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_op", out_op, 0);
    chk("arst_out_opnd1", out_operand1, 0);
    chk("arst_out_rob", out_rob_tag, 0);
    chk("arst_full", full, 0);
    tick();
    issue(6'd1, 32'h51, 32'h52, 4'd0, 4'd0, 4'd10);
    rst = 1'b0;
    tick();
    ena = 1'b0;
    chk("post_rst_early", out_valid, 0);
    tick();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_rob", out_rob_tag, 10);
    chk("post_rst_opnd1", out_operand1, 32'h51);
    tick();
    chk("post_rst_discard", out_valid, 0);

    // Select order: index 3 older than index 0, both woken together
    issue(6'd1, 32'h0, 32'h0, 4'd9, 4'd0, 4'd1);
    tick();
    issue(6'd1, 32'h0, 32'h0, 4'd8, 4'd0, 4'd2);
    tick();
    issue(6'd1, 32'h0, 32'h0, 4'd8, 4'd0, 4'd3);
    tick();
    issue(6'd1, 32'h0, 32'h0, 4'd7, 4'd0, 4'd4);
    tick();
    ena = 1'b0;
    cdb(1'b1, 4'd9, 32'h99);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    tick();
    chk("age_free_valid", out_valid, 1);
    chk("age_free_rob", out_rob_tag, 1);
    issue(6'd1, 32'h0, 32'h0, 4'd7, 4'd0, 4'd5);
    tick();
    ena = 1'b0;
    chk("age_reissue", out_valid, 0);
    cdb(1'b1, 4'd7, 32'h70);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    tick();
    chk("age_first_valid", out_valid, 1);
`ifdef RS_AGE_ORDER_EN
    chk("age_first_rob", out_rob_tag, 4);
`else
    chk("age_first_rob", out_rob_tag, 5);
`endif
    tick();
    chk("age_second_valid", out_valid, 1);
`ifdef RS_AGE_ORDER_EN
    chk("age_second_rob", out_rob_tag, 5);
`else
    chk("age_second_rob", out_rob_tag, 4);
`endif
    tick();
    chk("age_done", out_valid, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
